// File: rtl/inst_loader.sv
// Instruction memory loader: assembles a byte stream into 32-bit words.
// Optional trailing checksum byte: define INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_FIN,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdat_q, wdat_d;
  logic                wren_q, wren_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic        fire;
  logic [15:0] n_w;

  assign fire        = in_valid && in_ready;
  assign n_w         = {in_data, len_q[7:0]};
  assign mem_address = addr_q;
  assign mem_data    = wdat_q;
  assign mem_wren    = wren_q;
  assign core_hold   = hold_q;
  assign done        = done_q;
  assign error       = err_q;

  // Next-state, word assembly and write-port control
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    wren_d   = 1'b0;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    in_ready = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_LEN0, S_LEN1, S_DATA: in_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      S_CSUM:                 in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
    if (start && (state_q == S_IDLE || state_q == S_DONE
                  || state_q == S_ERR)) begin
      state_d = S_LEN0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      buf_d   = '0;
      addr_d  = '0;
      hold_d  = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        S_LEN0: if (fire) begin
          len_d   = {8'h00, in_data};
          state_d = S_LEN1;
        end
        S_LEN1: if (fire) begin
          len_d = n_w;
          if (n_w == 16'd0 || n_w > 16'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: if (fire) begin
          buf_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (idx_q == 2'd3) begin
            wdat_d = {in_data, buf_q[WORD_W-9:0]};
            addr_d = cnt_q[ADDR_W-1:0];
            wren_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == len_q) state_d = S_FIN;
          end
        end
        S_FIN: begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
`endif
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: if (fire) begin
          hold_d = 1'b0;
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wren_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wren_q  <= wren_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
